// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: instruction/data memory request-ready handshake between the sequencer and memories.
interface stage_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic ir_load;
    logic dmem_req;
    logic dmem_ready;
    modport master (output imem_req, ir_load, dmem_req, input imem_ready, dmem_ready);
    modport slave (input imem_req, ir_load, dmem_req, output imem_ready, dmem_ready);
endinterface

// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle RISC-V control FSM with PC priming and memory-wait timeout.
// Optional STAGE_SEQ_PERF_EN adds cycle/instret performance counters.
module stage_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    stage_sequencer_if.master mem,
    input  logic              mem_access_i,
    input  logic              wb_enable_i,
    input  logic              halt_req_i,
    output logic [1:0]        stage_o,
    output logic              pc_reset_o,
    output logic              rf_write_en_o,
    output logic              halted_o,
    output logic              fault_o
`ifdef STAGE_SEQ_PERF_EN
    ,
    output logic [31:0]       cycle_count_o,
    output logic [31:0]       instret_count_o
`endif
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {BOOT, PRIME, FETCH, DECODE, EXECUTE, MEM_WAIT, WRITEBACK, HALT} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fault_q, fault_d;
    logic          rdy, waiting, expired;
    always_comb begin
        rdy     = (state_q == FETCH) ? mem.imem_ready : mem.dmem_ready;
        waiting = (state_q == FETCH) || (state_q == MEM_WAIT);
        // a ready arriving at the limit wins over the timeout
        expired = waiting && !rdy && (cnt_q == CW'(TIMEOUT_CYCLES));
        fault_d = fault_q || expired;
        state_d = state_q;
        case (state_q)
            BOOT:      state_d = PRIME;
            PRIME:     state_d = FETCH;
            FETCH:     state_d = expired ? HALT : rdy ? DECODE : FETCH;
            DECODE:    state_d = halt_req_i ? HALT : EXECUTE;
            EXECUTE:   state_d = mem_access_i ? MEM_WAIT : WRITEBACK;
            MEM_WAIT:  state_d = expired ? HALT : rdy ? WRITEBACK : MEM_WAIT;
            WRITEBACK: state_d = FETCH;
            HALT:      state_d = HALT;
        endcase
        cnt_d = (state_d != state_q) ? '0 : (waiting && !rdy) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end
    assign stage_o = (state_q == DECODE) ? 2'd1 :
                     (state_q == EXECUTE || state_q == MEM_WAIT) ? 2'd2 :
                     (state_q == PRIME || state_q == WRITEBACK) ? 2'd3 : 2'd0;
    assign pc_reset_o    = state_q == BOOT;
    assign mem.imem_req  = state_q == FETCH;
    assign mem.ir_load   = (state_q == FETCH) && mem.imem_ready;
    assign mem.dmem_req  = state_q == MEM_WAIT;
    assign rf_write_en_o = (state_q == WRITEBACK) && wb_enable_i;
    assign halted_o      = state_q == HALT;
    assign fault_o       = fault_q;
`ifdef STAGE_SEQ_PERF_EN
    logic [31:0] cyc_q, ins_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            if (state_q != HALT) cyc_q <= cyc_q + 32'd1;
            if (state_q == WRITEBACK) ins_q <= ins_q + 32'd1;
        end
    end
    assign cycle_count_o   = cyc_q;
    assign instret_count_o = ins_q;
`endif
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: randomized instruction stream checked against a per-instruction expected-cycle model.
module tb_stage_sequencer;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    stage_sequencer_if mif();
    logic       ma = 1'b0, wb = 1'b0, hr = 1'b0;
    logic [1:0] stage;
    logic       pcr, rfw, hlt, flt;
`ifdef STAGE_SEQ_PERF_EN
    logic [31:0] cc, ic;
`endif
    stage_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .mem(mif),
        .mem_access_i(ma), .wb_enable_i(wb), .halt_req_i(hr),
        .stage_o(stage), .pc_reset_o(pcr), .rf_write_en_o(rfw), .halted_o(hlt), .fault_o(flt)
`ifdef STAGE_SEQ_PERF_EN
        , .cycle_count_o(cc), .instret_count_o(ic)
`endif
    );
    wire [8:0] obs = {stage, pcr, mif.imem_req, mif.ir_load, mif.dmem_req, rfw, hlt, flt};
    int errors = 0, checks = 0;
    int cc_m = 0, ic_m = 0;
    bit halted_m = 0, fault_m = 0;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [8:0] ex(int st, bit pr, bit iq, bit il, bit dq, bit rw, bit h, bit f);
        logic [1:0] s = st[1:0];
        return {s, pr, iq, il, dq, rw, h, f};
    endfunction
    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction
    task automatic cyc(string tag, logic ir, logic dr, logic m, logic w, logic h, logic [8:0] e, bit is_wb);
        @(negedge clk);
        mif.imem_ready = ir;
        mif.dmem_ready = dr;
        ma = m;
        wb = w;
        hr = h;
        #1;
        check(tag, obs, e);
`ifdef STAGE_SEQ_PERF_EN
        check("cycle_count", cc, cc_m);
        check("instret_count", ic, ic_m);
`endif
        if (!e[1]) cc_m++;
        if (is_wb) ic_m++;
    endtask
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_outputs", obs, ex(0, 1, 0, 0, 0, 0, 0, 0));
        cc_m = 0;
        ic_m = 0;
        halted_m = 0;
        fault_m = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc("boot", rnd(), rnd(), rnd(), rnd(), rnd(), ex(0, 1, 0, 0, 0, 0, 0, 0), 0);
        cyc("prime", rnd(), rnd(), rnd(), rnd(), rnd(), ex(3, 0, 0, 0, 0, 0, 0, 0), 0);
    endtask
    task automatic instr(int iw, bit m, int dw, bit w, bit h);
        for (int i = 0; i < iw && i <= TO; i++)
            cyc("fetch_wait", 1'b0, rnd(), rnd(), rnd(), rnd(), ex(0, 0, 1, 0, 0, 0, 0, 0), 0);
        if (iw > TO) begin
            halted_m = 1;
            fault_m = 1;
            return;
        end
        cyc("fetch_ready", 1'b1, rnd(), rnd(), rnd(), rnd(), ex(0, 0, 1, 1, 0, 0, 0, 0), 0);
        cyc("decode", rnd(), rnd(), rnd(), rnd(), h, ex(1, 0, 0, 0, 0, 0, 0, 0), 0);
        if (h) begin
            halted_m = 1;
            return;
        end
        cyc("execute", rnd(), rnd(), m, rnd(), rnd(), ex(2, 0, 0, 0, 0, 0, 0, 0), 0);
        if (m) begin
            for (int i = 0; i < dw && i <= TO; i++)
                cyc("mem_wait", rnd(), 1'b0, rnd(), rnd(), rnd(), ex(2, 0, 0, 0, 1, 0, 0, 0), 0);
            if (dw > TO) begin
                halted_m = 1;
                fault_m = 1;
                return;
            end
            cyc("mem_ready", rnd(), 1'b1, rnd(), rnd(), rnd(), ex(2, 0, 0, 0, 1, 0, 0, 0), 0);
        end
        cyc("writeback", rnd(), rnd(), rnd(), w, rnd(), ex(3, 0, 0, 0, 0, w, 0, 0), 1);
    endtask
    task automatic halt_run(int n);
        for (int i = 0; i < n; i++)
            cyc("halted", rnd(), rnd(), rnd(), rnd(), rnd(), ex(0, 0, 0, 0, 0, 0, 1, fault_m), 0);
    endtask
    initial begin
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) instr(0, 0, 0, 1'(i), 0);
`ifdef STAGE_SEQ_PERF_EN
        @(posedge clk);
        #1;
        check("perf_cycles_42", cc, 32'd42);
        check("perf_instret_10", ic, 32'd10);
`endif
        instr(3, 0, 0, 1, 0);
        instr(0, 1, 2, 0, 0);
        instr(TO, 1, TO, 1, 0);
        instr(0, 0, 0, 1, 1);
        halt_run(100);
        do_reset();
        instr(TO + 1, 0, 0, 0, 0);
        halt_run(5);
        do_reset();
        instr(0, 1, TO + 1, 1, 0);
        halt_run(5);
        do_reset();
        cyc("abort_fetch", 1'b1, rnd(), rnd(), rnd(), rnd(), ex(0, 0, 1, 1, 0, 0, 0, 0), 0);
        cyc("abort_decode", rnd(), rnd(), rnd(), rnd(), 1'b0, ex(1, 0, 0, 0, 0, 0, 0, 0), 0);
        cyc("abort_execute", rnd(), rnd(), 1'b1, rnd(), rnd(), ex(2, 0, 0, 0, 0, 0, 0, 0), 0);
        cyc("abort_mem_wait", rnd(), 1'b0, rnd(), rnd(), rnd(), ex(2, 0, 0, 0, 1, 0, 0, 0), 0);
        do_reset();
        for (int n = 0; n < 300; n++) begin
            int iw = ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, TO));
            int dw = ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, TO));
            instr(iw, rnd(), dw, rnd(), $urandom_range(0, 19) == 0);
            if (halted_m) begin
                halt_run(int'($urandom_range(1, 5)));
                do_reset();
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
